// File: rtl/mealy_seq_detector_pkg.sv
// Shared helpers for the serial pattern detector.
// Builds the prefix-tracking transition table from a constant pattern.
package seq_det_pkg;

  function automatic int STATE_W(input int width);
    return $clog2(width) + 1;
  endfunction

  // Bit i of the pattern counted from the first-received (MSB) end
  function automatic bit pat_bit(input logic [15:0] p, input int width, input int i);
    if (i < 0 || i >= width) return 1'b0;
    return p[width-1-i];
  endfunction

  function automatic int border_len(input logic [15:0] p, input int width);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < width; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++)
        if (pat_bit(p, width, i) != pat_bit(p, width, width - l + i)) ok = 1'b0;
      if (ok) best = l;
    end
    return best;
  endfunction

  // Longest pattern prefix that ends the string (first k pattern bits, b)
  function automatic int fail_next(input logic [15:0] p, input int width,
                                   input int k, input bit b);
    int best;
    int j;
    bit ok;
    bit sj;
    best = 0;
    for (int l = 1; l <= k; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        j  = k + 1 - l + i;
        sj = (j < k) ? pat_bit(p, width, j) : b;
        if (pat_bit(p, width, i) != sj) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  function automatic int next_state(input logic [15:0] p, input int width,
                                    input int k, input bit b, input bit overlap);
    if (k >= width) return 0;
    if (b == pat_bit(p, width, k)) begin
      if (k < width - 1) return k + 1;
      return overlap ? border_len(p, width) : 0;
    end
    return fail_next(p, width, k, b);
  endfunction

endpackage

// File: rtl/mealy_seq_detector_if.sv
// Serial input, match flag and status bundle for the pattern detector.
interface mealy_seq_detector_if #(
  parameter int CNT_W = 8,
  parameter int ST_W  = 3
);
  logic             en;
  logic             x;
  logic             clr_cnt;
  logic             Y;
  logic [CNT_W-1:0] match_count;
  logic [ST_W-1:0]  state_o;

  modport master (output en, x, clr_cnt, input Y, match_count, state_o);
  modport slave  (input en, x, clr_cnt, output Y, match_count, state_o);
endinterface

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (inc_i && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector with KMP fallback transitions.
// State is the matched-prefix length; the table is fixed at elaboration.
module mealy_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset,
  mealy_seq_detector_if.slave bus
);
  localparam int          SW    = STATE_W(WIDTH);
  localparam int          NS    = 2 ** SW;
  localparam logic [15:0] PAT16 = 16'(PATTERN);

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];
  logic [SW-1:0] state_q, state_d;
  logic          hit;

  // Unreachable encodings above WIDTH-1 fall back to the empty prefix
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam logic [SW-1:0] N0 = SW'(next_state(PAT16, WIDTH, k, 1'b0, OVERLAP));
    localparam logic [SW-1:0] N1 = SW'(next_state(PAT16, WIDTH, k, 1'b1, OVERLAP));
    assign nxt0[k] = N0;
    assign nxt1[k] = N1;
  end

  assign hit = bus.en & ~reset & (state_q == SW'(WIDTH - 1)) & (bus.x == PATTERN[0]);

  always_comb begin
    state_d = state_q;
    if (bus.en) state_d = bus.x ? nxt1[state_q] : nxt0[state_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign bus.Y       = hit;
  assign bus.state_o = state_q;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc_i (hit),
    .clr_i (bus.clr_cnt),
    .cnt_o (bus.match_count)
  );
endmodule

// File: tb/tb_mealy_seq_detector.sv
// Drives four detector configurations in lockstep against a history-based model.
module tb_mealy_seq_detector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mealy_seq_detector_if #(.CNT_W(8), .ST_W(3)) if0 ();
  mealy_seq_detector_if #(.CNT_W(8), .ST_W(3)) if1 ();
  mealy_seq_detector_if #(.CNT_W(2), .ST_W(3)) if2 ();
  mealy_seq_detector_if #(.CNT_W(8), .ST_W(1)) if3 ();

  mealy_seq_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  mealy_seq_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  mealy_seq_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  mealy_seq_detector #(.WIDTH(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(8))
    u3 (.clk(clk), .reset(reset), .bus(if3));

  // Model configuration and state: bit history since reset (or since last
  // non-overlapping match), newest bit in the LSB.
  int cw [4] = '{4, 4, 4, 1};
  int cp [4] = '{11, 11, 11, 1};
  int cov[4] = '{1, 0, 1, 1};
  int cmx[4] = '{255, 255, 3, 255};
  int h  [4];
  int n  [4];
  int cnt[4];
  int ymask[4];

  function automatic bit m_match(input int d, input bit xb);
    int v;
    v = ((h[d] << 1) | int'(xb)) & ((1 << cw[d]) - 1);
    return (n[d] >= cw[d] - 1) && (v == cp[d]);
  endfunction

  function automatic int m_state(input int d);
    int best;
    best = 0;
    for (int l = 1; l < cw[d]; l++)
      if (l <= n[d] && (h[d] & ((1 << l) - 1)) == (cp[d] >> (cw[d] - l))) best = l;
    return best;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      h[d] = 0; n[d] = 0; cnt[d] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit xb, input bit c);
    bit m;
    for (int d = 0; d < 4; d++) begin
      m = e && m_match(d, xb);
      if (c)                    cnt[d] = 0;
      else if (m && cnt[d] < cmx[d]) cnt[d] = cnt[d] + 1;
      if (e) begin
        if (m && cov[d] == 0) begin
          h[d] = 0; n[d] = 0;
        end else begin
          h[d] = ((h[d] << 1) | int'(xb)) & 16'hFFFF;
          n[d] = (n[d] < 16) ? n[d] + 1 : 16;
        end
      end
    end
  endtask

  task automatic set_in(input bit e, input bit xb, input bit c);
    if0.en = e; if0.x = xb; if0.clr_cnt = c;
    if1.en = e; if1.x = xb; if1.clr_cnt = c;
    if2.en = e; if2.x = xb; if2.clr_cnt = c;
    if3.en = e; if3.x = xb; if3.clr_cnt = c;
  endtask

  task automatic get_obs(input int d, output bit y, output int st, output int ct);
    case (d)
      0:       begin y = if0.Y; st = int'(if0.state_o); ct = int'(if0.match_count); end
      1:       begin y = if1.Y; st = int'(if1.state_o); ct = int'(if1.match_count); end
      2:       begin y = if2.Y; st = int'(if2.state_o); ct = int'(if2.match_count); end
      default: begin y = if3.Y; st = int'(if3.state_o); ct = int'(if3.match_count); end
    endcase
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
  task automatic drive_check(input string tag, input bit e, input bit xb, input bit c);
    bit y, ey;
    int st, ct;
    set_in(e, xb, c);
    #1;
    for (int d = 0; d < 4; d++) begin
      get_obs(d, y, st, ct);
      ey = e && !reset && m_match(d, xb);
      ymask[d] = (ymask[d] << 1) | int'(y);
      checks++;
      if (y !== ey) begin
        errors++; $display("FAIL %s dut%0d Y: got %0b want %0b", tag, d, y, ey);
      end
      checks++;
      if (st != m_state(d)) begin
        errors++; $display("FAIL %s dut%0d state_o: got %0d want %0d", tag, d, st, m_state(d));
      end
      checks++;
      if (ct != cnt[d]) begin
        errors++; $display("FAIL %s dut%0d match_count: got %0d want %0d", tag, d, ct, cnt[d]);
      end
    end
    @(posedge clk);
    if (reset) model_reset();
    else       model_step(e, xb, c);
    @(negedge clk);
  endtask

  // Async pulse entirely between edges, with a would-be completing bit applied.
  task automatic reset_pulse(input string tag);
    bit y;
    int st, ct;
    #1;
    set_in(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    model_reset();
    #2;
    for (int d = 0; d < 4; d++) begin
      get_obs(d, y, st, ct);
      checks++;
      if (y !== 1'b0 || st != 0 || ct != 0) begin
        errors++;
        $display("FAIL %s dut%0d during reset: Y=%0b state=%0d cnt=%0d want 0/0/0", tag, d, y, st, ct);
      end
    end
    set_in(1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_masks();
    for (int d = 0; d < 4; d++) ymask[d] = 0;
  endtask

  task automatic drive_bits(input string tag, input logic [31:0] bits, input int len);
    logic [31:0] b;
    b = bits;
    for (int i = len - 1; i >= 0; i--) drive_check(tag, 1'b1, b[i], 1'b0);
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++; $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_check("reset_hold", 1'b1, 1'b1, 1'b0);
    expect_int("reset_state", int'(if0.state_o), 0);
    expect_int("reset_count", int'(if0.match_count), 0);
    reset = 1'b0;
  endtask

  task automatic test_overlap();
    reset_pulse("ovl_pre");
    clear_masks();
    drive_bits("ovl", 32'b1011011, 7);
    expect_int("ovl_ymask_ov1", ymask[0], 7'b0001001);
    expect_int("ovl_ymask_ov0", ymask[1], 7'b0001000);
    expect_int("ovl_count_ov1", int'(if0.match_count), 2);
    expect_int("ovl_count_ov0", int'(if1.match_count), 1);
  endtask

  task automatic test_fallback();
    reset_pulse("fb_pre");
    clear_masks();
    drive_bits("fb", 32'b1010, 4);
    expect_int("fb_state_after_mismatch", int'(if0.state_o), 2);
    drive_bits("fb", 32'b11, 2);
    expect_int("fb_ymask", ymask[0], 6'b000001);
    expect_int("fb_count", int'(if0.match_count), 1);
  endtask

  task automatic test_enable_hold();
    reset_pulse("en_pre");
    clear_masks();
    drive_bits("en", 32'b101, 3);
    for (int i = 0; i < 5; i++) drive_check("en_hold", 1'b0, i[0], 1'b0);
    expect_int("en_state_held", int'(if0.state_o), 3);
    drive_check("en_resume", 1'b1, 1'b1, 1'b0);
    expect_int("en_ymask", ymask[0], 9'b000000001);
    expect_int("en_count", int'(if0.match_count), 1);
  endtask

  task automatic test_saturate_clear();
    reset_pulse("sat_pre");
    drive_bits("sat", 32'b1011011011011011, 16);
    expect_int("sat_count_w2", int'(if2.match_count), 3);
    expect_int("sat_count_w8", int'(if0.match_count), 5);
    drive_bits("clr", 32'b01, 2);
    clear_masks();
    drive_check("clr_hit", 1'b1, 1'b1, 1'b1);
    expect_int("clr_y_on_edge", ymask[2], 1);
    expect_int("clr_count_w2", int'(if2.match_count), 0);
    expect_int("clr_state_kept", int'(if2.state_o), 1);
  endtask

  task automatic test_async_reset();
    reset_pulse("ar_pre");
    clear_masks();
    drive_bits("ar", 32'b101, 3);
    reset_pulse("ar_pulse");
    drive_check("ar_after", 1'b1, 1'b1, 1'b0);
    expect_int("ar_no_y", ymask[0] & 1, 0);
    expect_int("ar_count", int'(if0.match_count), 0);
  endtask

  task automatic test_random();
    bit e, xb, c;
    reset_pulse("rnd_pre");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) reset_pulse("rnd_pulse");
      e  = ($urandom_range(9) < 8);
      xb = $urandom_range(1) == 1;
      c  = ($urandom_range(39) == 0);
      drive_check("rnd", e, xb, c);
    end
  endtask

  initial begin
    model_reset();
    clear_masks();
    set_in(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    test_reset();
    test_overlap();
    test_fallback();
    test_enable_hold();
    test_saturate_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
